// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared state encoding and stream-format constants for imem_loader.
// Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_LAST = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = 2;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Brief    : Packs accepted bytes MSB-first into 32-bit words, one-cycle strobe.
// Revision : 1.0  initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [LANE_W-1:0] r_lane;
    logic [23:0]       r_shift;

    // The strobe fires in the cycle the final byte is presented so the
    // consumer can register the word at the same edge that accepts it.
    assign word_valid = byte_valid && (r_lane == LANE_W'(WORD_BYTES - 1));
    assign word_data  = {r_shift, byte_data};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (byte_valid) begin
            r_lane  <= r_lane + LANE_W'(1);
            r_shift <= {r_shift[15:0], byte_data};
        end
    end

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot loader streaming a word image into instruction RAM while the
//            CPU is held in reset. Define IMEM_LOADER_CHECKSUM_EN for checksum.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              iram_ena,
    output logic              iram_wena,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [31:0]       iram_indata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);
    localparam logic [32:0]       c_depth = 33'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t c_after_data = ST_CSUM;
`else
    localparam state_t c_after_data = ST_LAST;
`endif
    // An empty image has nothing to drain, so it skips LAST.
    localparam state_t c_after_empty = (c_after_data == ST_CSUM) ? ST_CSUM : ST_RUN;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_write;
    logic              w_last_word;
    logic [ADDR_W:0]   r_target;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       r_csum;
`endif

    assign rx_ready    = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_accept    = rx_valid && rx_ready;
    assign w_clear     = ((r_state == ST_RUN) || (r_state == ST_ERR)) && load_req;
    assign w_write     = (r_state == ST_DATA) && w_word_valid;
    assign w_last_word = w_write && ((words_loaded + (ADDR_W+1)'(1)) == r_target);
    assign iram_ena    = iram_wena;

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .byte_valid (w_accept),
        .byte_data  (rx_data),
        .word_valid (w_word_valid),
        .word_data  (w_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_word_valid) begin
                    if (w_word == 32'd0)
                        w_next = c_after_empty;
                    else if ({1'b0, w_word} > c_depth)
                        w_next = ST_ERR;
                    else
                        w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_last_word)
                    w_next = c_after_data;
            end
            ST_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_word_valid)
                    w_next = (w_word == r_csum) ? ST_RUN : ST_ERR;
`else
                w_next = ST_ERR;
`endif
            end
            ST_LAST:         w_next = ST_RUN;
            ST_RUN, ST_ERR: begin
                if (load_req)
                    w_next = ST_HDR;
            end
            default:         w_next = ST_HDR;
        endcase
    end

    // Status flags decode the next state so they change on the same edge as
    // the state register rather than one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HDR;
            iram_wena    <= 1'b0;
            iram_addr    <= '0;
            iram_indata  <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            r_target     <= '0;
        end else begin
            r_state   <= w_next;
            iram_wena <= w_write;
            cpu_rst   <= (w_next != ST_RUN);
            load_done <= (w_next == ST_RUN);
            load_err  <= (w_next == ST_ERR);
            if (w_write) begin
                iram_addr   <= c_base + words_loaded[ADDR_W-1:0];
                iram_indata <= w_word;
            end
            if (w_clear)
                words_loaded <= '0;
            else if (w_write)
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
            if ((r_state == ST_HDR) && w_word_valid)
                r_target <= w_word[ADDR_W:0];
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || w_clear)
            r_csum <= '0;
        else if (w_write)
            r_csum <= r_csum + w_word;
    end
`endif

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Randomized scoreboard bench for imem_loader (either checksum build).
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              load_req;
    logic              iram_ena;
    logic              iram_wena;
    logic [ADDR_W-1:0] iram_addr;
    logic [31:0]       iram_indata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .iram_ena     (iram_ena),
        .iram_wena    (iram_wena),
        .iram_addr    (iram_addr),
        .iram_indata  (iram_indata),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    wr_t         exp_q[$];
    logic [31:0] img[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write strobe is matched against the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (iram_wena === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         iram_addr, iram_indata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(iram_addr), 64'(e.addr));
                chk("write_data", 64'(iram_indata), 64'(e.data));
                chk("write_ena", 64'(iram_ena), 64'd1);
            end
        end
    end

    function automatic logic [31:0] img_sum();
        logic [31:0] s = '0;
        foreach (img[i]) s += img[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got rx_ready %b, expected 1", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int b = 3; b >= 0; b--)
            send_byte(w[b*8 +: 8], int'($urandom_range(0, maxgap)));
    endtask

    // Reference model: decides outcome, drain latency and expected writes from
    // the stream rules alone, then drives the stream and checks the end state.
    task automatic load_image(input logic [31:0] n, input logic [31:0] csum,
                              input int maxgap, input string tag);
        bit oversize;
        bit expect_run;
        bit drain;
        oversize = (n > DEPTH);
        send_word(n, maxgap);
        if (!oversize) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back('{addr: ADDR_W'(i), data: img[i]});
                send_word(img[i], maxgap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!oversize) send_word(csum, maxgap);
        expect_run = !oversize && (csum == img_sum());
        drain      = 1'b0;
`else
        expect_run = !oversize;
        drain      = !oversize && (n != 0);
        if (csum != csum) expect_run = 1'b0;
`endif
        @(negedge clk);
        if (drain) begin
            chk({tag, "_drain_cpu_rst"}, 64'(cpu_rst), 64'd1);
            chk({tag, "_drain_done"}, 64'(load_done), 64'd0);
            @(negedge clk);
        end
        #1;
        chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!expect_run));
        chk({tag, "_load_done"}, 64'(load_done), 64'(expect_run));
        chk({tag, "_load_err"}, 64'(load_err), 64'(!expect_run));
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), oversize ? 64'd0 : 64'(n));
        chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reload(input string tag);
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        chk({tag, "_req_cpu_rst"}, 64'(cpu_rst), 64'd1);
        chk({tag, "_req_done"}, 64'(load_done), 64'd0);
        chk({tag, "_req_err"}, 64'(load_err), 64'd0);
        chk({tag, "_req_rx_ready"}, 64'(rx_ready), 64'd1);
        chk({tag, "_req_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        load_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("rst_ena", 64'(iram_ena), 64'd0);
        chk("rst_wena", 64'(iram_wena), 64'd0);
        chk("rst_addr", 64'(iram_addr), 64'd0);
        chk("rst_indata", 64'(iram_indata), 64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);

        img = '{32'h20010005, 32'h20020003, 32'h00221820};
        load_image(3, img_sum(), 0, "basic");

        // Bytes offered while running must be refused.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("lockout_rx_ready", 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
        chk("lockout_words", 64'(words_loaded), 64'd3);
        chk("lockout_cpu_rst", 64'(cpu_rst), 64'd0);

        reload("stall");
        load_image(3, img_sum(), 5, "stall");

        reload("empty");
        img.delete();
        load_image(0, 32'd0, 0, "empty");

        reload("oversize");
        load_image(257, 32'd0, 2, "oversize");

        reload("after_err");
        img = '{$urandom()};
        load_image(1, img_sum(), 3, "after_err");

        // Reset in the middle of the second data word.
        reload("midrst");
        img = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        exp_q.push_back('{addr: '0, data: img[0]});
        send_word(3, 0);
        send_word(img[0], 0);
        send_byte(img[1][31:24], 0);
        send_byte(img[1][23:16], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rx_ready", 64'(rx_ready), 64'd1);
        chk("midrst_wena", 64'(iram_wena), 64'd0);
        chk("midrst_words", 64'(words_loaded), 64'd0);
        chk("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("midrst_pending", 64'(exp_q.size()), 64'd0);
        img = '{32'hDEADBEEF};
        load_image(1, img_sum(), 0, "deadbeef");

        for (int r = 0; r < 4; r++) begin
            reload("random");
            n = int'($urandom_range(1, 8));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom());
            load_image(32'(n), img_sum(), 4, "random");
        end

        reload("full");
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom());
        load_image(DEPTH, img_sum(), 0, "full");

`ifdef IMEM_LOADER_CHECKSUM_EN
        reload("csum_ok");
        img = '{32'd1, 32'd2};
        load_image(2, 32'd3, 1, "csum_ok");
        reload("csum_bad");
        load_image(2, 32'd4, 1, "csum_bad");
        reload("csum_wrap");
        img = '{32'hFFFFFFFF, 32'h00000002};
        load_image(2, 32'h00000001, 1, "csum_wrap");
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
